// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings for the CPU memory-port arbiter: FSM states, channel owners
// and the all-ones strobe pattern used for reads.
package cpu_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Wide enough for any supported data width; users slice the low bits.
    localparam int               STRB_MAX_W    = 64;
    localparam logic [STRB_MAX_W-1:0] STRB_ALL_ONES = '1;

endpackage

// File: rtl/cpu_mem_arbiter_grant.sv
// Grant selection between fetch and data channels (fixed priority or
// round-robin) together with the last-owner register.
module mem_arb_grant
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic sys_clk,
    input  logic sys_reset_n,
    input  logic eval_en,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_valid,
    output logic grant_owner
);

    logic last_owner;

    always_comb begin
        grant_valid = eval_en & (inst_req | data_req);
        grant_owner = OWN_INST;
        if (inst_req && data_req) begin
            grant_owner = (RR_EN != 0) ? ~last_owner : OWN_DATA;
        end else if (data_req) begin
            grant_owner = OWN_DATA;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            last_owner <= OWN_INST;
        end else if (grant_valid) begin
            last_owner <= grant_owner;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between CPU fetch and data channels, one transaction
// at a time, buffering read responses and counting grants per channel.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 0
) (
    input  logic                sys_clk,
    input  logic                sys_reset_n,
    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ready,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ready,
    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    output logic                Mem_Req_Ack,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ready,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rdata_valid,
    output logic                mem_rdata_ready,
    output logic [31:0]         inst_grant_cnt,
    output logic [31:0]         data_grant_cnt
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        state;
    logic              owner;
    logic [DATA_W-1:0] rsp_buf;
    logic              data_req;
    logic              grant_valid;
    logic              grant_owner;
    logic              in_issue;
    logic              in_resp;
    logic              is_write;
    logic              resp_taken;

    assign data_req = MemRead | MemWrite;
    assign in_issue = (state == ST_ISSUE);
    assign in_resp  = (state == ST_RESP);
    // A data request with MemWrite set is a write even if MemRead is also high.
    assign is_write = (owner == OWN_DATA) & MemWrite;

    mem_arb_grant #(
        .RR_EN (RR_EN)
    ) u_grant (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .eval_en     (state == ST_IDLE),
        .inst_req    (Inst_Req_Valid),
        .data_req    (data_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Valid/ready: a transfer happens on any rising edge where both are high;
    // a requester holds its request and payload until its ready/ack is seen.
    always_comb begin
        mem_req_valid   = in_issue;
        Inst_Req_Ready  = in_issue & (owner == OWN_INST) & mem_req_ready;
        Mem_Req_Ack     = in_issue & (owner == OWN_DATA) & mem_req_ready;
        mem_wen         = in_issue & is_write;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        if (in_issue) begin
            mem_addr  = (owner == OWN_DATA) ? Address : PC;
            mem_wstrb = is_write ? Write_strb : STRB_ALL_ONES[STRB_W-1:0];
            if (is_write) begin
                mem_wdata = Write_data;
            end
        end
        mem_rdata_ready = (state == ST_WAIT_RD);
        Inst_Valid      = in_resp & (owner == OWN_INST);
        Read_data_Valid = in_resp & (owner == OWN_DATA);
        Instruction     = Inst_Valid ? rsp_buf : '0;
        Read_data       = Read_data_Valid ? rsp_buf : '0;
        resp_taken      = (owner == OWN_INST) ? Inst_Ready : Read_data_Ready;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state          <= ST_IDLE;
            owner          <= OWN_INST;
            rsp_buf        <= '0;
            inst_grant_cnt <= '0;
            data_grant_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_owner;
                        if (grant_owner == OWN_DATA) begin
                            data_grant_cnt <= data_grant_cnt + 32'd1;
                        end else begin
                            inst_grant_cnt <= inst_grant_cnt + 32'd1;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        state <= is_write ? ST_IDLE : ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (mem_rdata_valid) begin
                        rsp_buf <= mem_rdata;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_taken) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Shares one memory port between the instruction-fetch channel and the data channel of the multi-cycle custom CPU. It sits between u_cpu and the memory/UART interconnect inside cpu_test_top. It sequences one transaction at a time (grant, issue, read-response buffering) and keeps per-channel grant counters for performance reporting.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
RR_EN, 0, arbitration mode: 0 = fixed priority (data over inst); 1 = round-robin

Ports:
sys_clk  in  1  clock
sys_reset_n  in  1  asynchronous, active-low reset
PC  in  ADDR_W  instruction fetch address
Inst_Req_Valid  in  1  fetch request
Inst_Req_Ready  out  1  fetch request accepted
Instruction  out  DATA_W  fetched instruction
Inst_Valid  out  1  instruction valid
Inst_Ready  in  1  CPU accepts instruction
Address  in  ADDR_W  data address
MemRead  in  1  data read request
MemWrite  in  1  data write request
Write_data  in  DATA_W  store data
Write_strb  in  DATA_W/8  byte strobes
Mem_Req_Ack  out  1  data request accepted
Read_data  out  DATA_W  load data
Read_data_Valid  out  1  load data valid
Read_data_Ready  in  1  CPU accepts load data
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepts request
mem_wen  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_wstrb  out  DATA_W/8  downstream strobes; all-ones on reads
mem_rdata  in  DATA_W  downstream read data
mem_rdata_valid  in  1  read data valid
mem_rdata_ready  out  1  arbiter accepts read data
inst_grant_cnt  out  32  count of fetch grants
data_grant_cnt  out  32  count of data grants

Behaviour:
- Reset (asynchronous, sys_reset_n=0): state=IDLE; all valid, ready and ack outputs are 0; Instruction, Read_data, the response buffer and both counters are 0; the round-robin last-owner register is set to INST. Reset asserted mid-transaction aborts it and discards any buffered data. Downstream completion of the aborted transaction is not tracked.
- States: IDLE, ISSUE, WAIT_RD, RESP. The owner register (INST/DATA) is written only in IDLE.
- IDLE: a data request is MemRead|MemWrite; a fetch request is Inst_Req_Valid.
  - If neither is pending, stay in IDLE.
  - If exactly one is pending, grant it.
  - If both are pending: with RR_EN=0, grant DATA; with RR_EN=1, grant the channel that is not the last owner.
  - On a grant, latch the owner, increment the matching counter (wraps 0xFFFFFFFF→0), and go to ISSUE. The earliest mem_req_valid is one cycle after the request.
- ISSUE: mem_req_valid=1; mem_addr, mem_wdata, mem_wstrb and mem_wen are driven combinationally from the owner's inputs.
  - Requesters must hold their request until acked. Deassertion in ISSUE is a protocol error; the arbiter keeps mem_req_valid high regardless.
  - Owner's ready (Inst_Req_Ready or Mem_Req_Ack) = mem_req_ready, combinational, asserted only in ISSUE.
  - On the handshake: a write (MemWrite) goes to IDLE with no response; a read goes to WAIT_RD.
  - MemRead and MemWrite both high is treated as a write.
  - A fetch is always a read with mem_wstrb all-ones.
- WAIT_RD: mem_rdata_ready=1. On mem_rdata_valid, capture mem_rdata into the buffer and go to RESP.
- RESP: assert Inst_Valid or Read_data_Valid (owner only), with Instruction or Read_data driven from the buffer. Hold until the owner's Inst_Ready or Read_data_Ready, then go to IDLE. Data stays stable while valid is high.
- Back-to-back: the new grant is evaluated in the IDLE cycle after completion. A write therefore costs at least 2 cycles and a read at least 4.
- Never more than one outstanding transaction. The non-owner's ready/valid outputs are always 0.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/WAIT_RD/RESP), owner encoding (OWN_INST/OWN_DATA), strobe all-ones constant.
- One natural sub-module: mem_arb_grant, the combinational priority/round-robin grant logic plus the last-owner register.

Test Plan:
- Fetch only: PC=0x100 with Inst_Req_Valid; memory returns 0x00000013 → mem_req_valid one cycle later, mem_addr=0x100, mem_wen=0; Inst_Valid with Instruction=0x13 held until Inst_Ready; inst_grant_cnt=1.
- Store: Address=0x0C, Write_data=0, Write_strb=0xF, mem_req_ready stalled 3 cycles → mem_req_valid held 3 cycles; Mem_Req_Ack on cycle 4; returns to IDLE; no Read_data_Valid.
- Simultaneous fetch (PC=0x200) and load (Address=0x400) with RR_EN=0 → load granted first; fetch issued after the load response handshake. With RR_EN=1 and last owner DATA → fetch granted first.
- Response backpressure: Read_data_Ready held low 5 cycles after load data 0xDEADBEEF → Read_data_Valid and Read_data stable for all 5 cycles; no new mem_req_valid during them.
- Reset mid-WAIT_RD: drop sys_reset_n → all outputs 0 immediately, counters 0. After release, a new fetch proceeds normally.
- Counter wrap: preload via 2^32 grants (or a forced counter value of 0xFFFFFFFF) → next grant yields 0.
